// File: rtl/instr_line_buffer_pkg.sv
// Shared definitions for the instruction line buffer and the fetch unit it serves.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package instr_line_buffer_pkg;

    localparam int ILB_INSTR_W = 32;
    localparam int ILB_DEPTH   = 32;
    localparam int ILB_ADDR_W  = 5;
    // Fetch PC width; the fetch unit sizes its PC register from this.
    localparam int ILB_PC_W    = ILB_ADDR_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_FLUSH = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } ilb_state_t;

endpackage

// File: rtl/ilb_mem.sv
// Instruction store: one write port, two reads at addr and addr+1 (mod depth).
// Latency: reads are registered, data appears 1 cycle after rd_en.
// Backpressure: none; caller guarantees writes and reads never coincide.
module ilb_mem
    import instr_line_buffer_pkg::*;
#(
    parameter int INSTR_W = ILB_INSTR_W,
    parameter int DEPTH   = ILB_DEPTH,
    parameter int ADDR_W  = ILB_PC_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [INSTR_W-1:0] wr_data,
    input  logic               rd_en,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [INSTR_W-1:0] rd_data_0,
    output logic [INSTR_W-1:0] rd_data_1
);

    logic [INSTR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]  rd_addr_1;

    // Second slot address wraps naturally at the power-of-two depth.
    assign rd_addr_1 = rd_addr + 1'b1;

    // Storage array: no reset, contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered dual read; holds last data when not reading.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_0 <= '0;
            rd_data_1 <= '0;
        end else if (rd_en) begin
            rd_data_0 <= mem[rd_addr];
            rd_data_1 <= mem[rd_addr_1];
        end
    end

endmodule

// File: rtl/instr_line_buffer.sv
// Holds the loaded program and returns the instruction pair at pc / pc+1 to the fetch unit.
// Latency: 1 cycle from pc to instr_0/instr_1/valid_0/valid_1.
// Backpressure: load_ready is high only in IDLE/LOAD/DONE; words are dropped by nobody, loader waits.
module instr_line_buffer
    import instr_line_buffer_pkg::*;
#(
    parameter int INSTR_W = ILB_INSTR_W,
    parameter int DEPTH   = ILB_DEPTH,
    parameter int ADDR_W  = ILB_ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr_0,
    output logic [INSTR_W-1:0] instr_1,
    output logic               valid_0,
    output logic               valid_1,
    output logic               active,
    output logic               fetch_reset,
    output logic [ADDR_W:0]    prog_len,
    output logic               done
);

    // prog_len value at which the next accept fills the buffer.
    localparam logic [ADDR_W:0] LEN_LAST = (ADDR_W + 1)'(DEPTH - 1);

    ilb_state_t          state;
    ilb_state_t          next_state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   wr_addr;
    logic                accept;
    logic [ADDR_W:0]     pc_ext;
    logic [ADDR_W:0]     pc_inc;

    assign accept  = load_valid & load_ready;
    // A fresh load (from IDLE or DONE) always starts at address 0.
    assign wr_addr = (state == ST_LOAD) ? wr_ptr : '0;
    // pc+1 kept one bit wider so pc=31 compares as 32, never as a wrapped 0.
    assign pc_ext  = {1'b0, pc};
    assign pc_inc  = pc_ext + 1'b1;

    ilb_mem #(
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (accept),
        .wr_addr   (wr_addr),
        .wr_data   (load_data),
        .rd_en     (state == ST_RUN),
        .rd_addr   (pc),
        .rd_data_0 (instr_0),
        .rd_data_1 (instr_1)
    );

    // Next-state decode; RUN exits on the same edge that registers an out-of-program read.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    next_state = load_last ? ST_FLUSH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept && (load_last || prog_len == LEN_LAST)) begin
                    next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: next_state = ST_RUN;
            ST_RUN: begin
                if (pc_ext >= prog_len) begin
                    next_state = ST_DONE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // State, load counters and registered control outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            prog_len    <= '0;
            load_ready  <= 1'b0;
            active      <= 1'b0;
            fetch_reset <= 1'b0;
            done        <= 1'b0;
            valid_0     <= 1'b0;
            valid_1     <= 1'b0;
        end else begin
            state       <= next_state;
            load_ready  <= (next_state == ST_IDLE) || (next_state == ST_LOAD) ||
                           (next_state == ST_DONE);
            active      <= (next_state == ST_RUN);
            fetch_reset <= (next_state == ST_FLUSH);
            done        <= (next_state == ST_DONE);
            valid_0     <= (state == ST_RUN) && (pc_ext < prog_len);
            valid_1     <= (state == ST_RUN) && (pc_inc < prog_len);
            if (accept) begin
                if (state == ST_LOAD) begin
                    wr_ptr   <= wr_ptr + 1'b1;
                    prog_len <= prog_len + 1'b1;
                end else begin
                    wr_ptr   <= ADDR_W'(1);
                    prog_len <= (ADDR_W + 1)'(1);
                end
            end
        end
    end

endmodule

// File: doc/instr_line_buffer.md
Name: instr_line_buffer

Overview:
- Responder side of the fetch PC interface: holds the instruction program and returns two instructions per fetch PC.
- Sequence: loads the program through a valid/ready load port, pulses fetch_reset, then raises active so the fetch unit starts issuing PCs.
- On each PC it returns the instruction pair at PC and PC+1, with per-slot valid bits.
- Drops active once the program has been fully fetched.

Parameters:
- INSTR_W, 32, instruction word width.
- DEPTH, 32, number of instruction entries; fixed to match the 5-bit PC.
- ADDR_W, 5, address width, log2(DEPTH).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  loader presents a word.
- load_data  input  INSTR_W  instruction word.
- load_last  input  1  qualifies the final word of the program.
- load_ready  output  1  buffer accepts a word this cycle.
- pc  input  ADDR_W  fetch PC; the address of slot 0.
- instr_0  output  INSTR_W  instruction at pc, registered.
- instr_1  output  INSTR_W  instruction at pc+1, registered.
- valid_0  output  1  instr_0 lies inside the loaded program.
- valid_1  output  1  instr_1 lies inside the loaded program.
- active  output  1  enables the fetch unit.
- fetch_reset  output  1  one-cycle pulse that zeroes the fetch PC before a run.
- prog_len  output  ADDR_W+1  number of loaded words, 0..32.
- done  output  1  program exhausted.

Behaviour:
- Reset (async, via the already-decided reset): state IDLE; prog_len=0; wr_ptr=0; load_ready=0; active=0; fetch_reset=0; done=0; instr_0=instr_1=0; valid_0=valid_1=0. Memory contents are not cleared.
- States: IDLE, LOAD, FLUSH, RUN, DONE.
- IDLE: load_ready=1 from the first cycle after reset release. The first accepted word (load_valid & load_ready) is written to address 0, sets prog_len=1 and moves the state to LOAD; if load_last is also set, the state goes straight to FLUSH.
- LOAD: load_ready=1. Each accepted word is written at wr_ptr; wr_ptr and prog_len increment.
  - Accept with load_last -> FLUSH.
  - Accept of the 32nd word (prog_len becomes 32) -> FLUSH, even without load_last.
  - load_valid low -> hold the state; no timeout.
- FLUSH: exactly one cycle. load_ready=0, fetch_reset=1, active=0. Next state RUN.
- RUN: active=1, load_ready=0; load_valid is ignored.
  - Read latency is 1 cycle: at each posedge, instr_0<=mem[pc] and instr_1<=mem[(pc+1) mod 32].
  - valid_0 <= (pc < prog_len). valid_1 <= ((pc+1) < prog_len), with pc+1 computed at 6 bits so pc=31 gives 32 and valid_1=0. No wrap-around fetch is ever flagged valid.
  - Backward PC steps (hazard rollback) are serviced like any other PC; no internal state depends on PC history.
  - Exit when a registered read has valid_0=0 (pc >= prog_len) -> DONE.
- DONE: done=1, active=0. valid_0 and valid_1 are forced to 0; instr outputs hold their last values. load_ready=1.
  - The first accepted word restarts the load at address 0: prog_len=1, done=0, next state LOAD (or FLUSH if load_last is set).
- Memory write and read never coincide: writes happen only in IDLE/LOAD/DONE, reads only in RUN.
- Reset mid-LOAD or mid-RUN: immediate return to the reset values; a partial program is discarded logically (prog_len=0).

Decomposition:
- Shared package:
  - state encoding (IDLE=0, LOAD=1, FLUSH=2, RUN=3, DONE=4, 3 bits);
  - DEPTH, ADDR_W and INSTR_W constants;
  - a PC-width constant shared with the fetch unit.
- Sub-module ilb_mem: a 32 x INSTR_W array with one write port and two registered read ports (addresses pc and pc+1 mod 32).
- The FSM, counters and valid logic stay in the top level.

Test Plan:
- Load 4 words 0xA0..0xA3 with load_last on the 4th -> prog_len=4; FLUSH one cycle with fetch_reset=1; then active=1. pc=0 -> next cycle instr_0=0xA0, instr_1=0xA1, valid=11.
- Same program, pc=3 -> instr_0=0xA3, valid_0=1, valid_1=0. Then pc=4 -> valid_0=0, next state DONE, done=1, active=0.
- Load 32 words without load_last -> auto-FLUSH after the 32nd accept, prog_len=32. pc=31 -> instr_0=word31, instr_1=word0, valid_0=1, valid_1=0.
- Hold load_valid low for 5 cycles during LOAD -> state stays LOAD, prog_len unchanged, no fetch_reset.
- In RUN drive pc 6,4,6 (rollback pattern), prog_len=10 -> outputs follow each pc with 1-cycle latency, all valid; load_valid pulses are ignored with load_ready=0.
- Assert reset during LOAD after 3 words -> prog_len=0, IDLE, active=0. Reload 2 words -> normal FLUSH/RUN with prog_len=2.
